// File: rtl/clint_timer.sv
// Single-hart CLINT: 64-bit mtime/mtimecmp and msip behind a 32-bit Wishbone-style slave.
// Raises mtip when mtime >= mtimecmp; exports mtime for the time CSR.
module clint_timer #(
    parameter int unsigned CLOCK_DIV      = 1,
    parameter logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cyc,
    input  logic        stb,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [3:0]  sel,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    output logic        ack,
    output logic        msip,
    output logic        mtip,
    output logic [63:0] mtime_o
);

    localparam int unsigned PW = (CLOCK_DIV > 1) ? $clog2(CLOCK_DIV) : 1;
    localparam logic [PW-1:0] PrescMax = PW'(CLOCK_DIV - 1);

    typedef enum logic [2:0] {RegNone, RegMsip, RegCmpLo, RegCmpHi, RegTimeLo, RegTimeHi} reg_e;

    logic [PW-1:0] presc_q, presc_d;
    logic [63:0]   mtime_q, mtime_d;
    logic [63:0]   cmp_q, cmp_d;
    logic          msip_q, msip_d;
    logic          mtip_q, mtip_d;
    logic          ack_q, ack_d;
    logic [31:0]   dat_q, dat_d;
    logic [31:0]   rdata;
    logic          req, wr, tick;
    reg_e          reg_sel;

    // Word offset only; the byte offset within a word has no meaning here.
    logic unused_addr;
    assign unused_addr = ^addr[1:0];

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  lanes);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return res;
    endfunction

    always_comb begin
        case (addr[15:2])
            14'h0000: reg_sel = RegMsip;
            14'h1000: reg_sel = RegCmpLo;
            14'h1001: reg_sel = RegCmpHi;
            14'h2FFE: reg_sel = RegTimeLo;
            14'h2FFF: reg_sel = RegTimeHi;
            default:  reg_sel = RegNone;
        endcase
    end

    always_comb begin
        req     = cyc & stb & ~ack_q;
        wr      = req & we;
        tick    = (presc_q == PrescMax);
        presc_d = tick ? '0 : presc_q + 1'b1;
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
        cmp_d   = cmp_q;
        msip_d  = msip_q;
        mtip_d  = (mtime_q >= cmp_q);
        ack_d   = req;

        case (reg_sel)
            RegMsip:   rdata = {31'd0, msip_q};
            RegCmpLo:  rdata = cmp_q[31:0];
            RegCmpHi:  rdata = cmp_q[63:32];
            RegTimeLo: rdata = mtime_q[31:0];
            RegTimeHi: rdata = mtime_q[63:32];
            default:   rdata = '0;
        endcase
        dat_d = (req & ~we) ? rdata : '0;

        // A bus write to mtime overrides the tick increment for the whole 64-bit value.
        if (wr) begin
            case (reg_sel)
                RegMsip:   if (sel[0]) msip_d = dat_i[0];
                RegCmpLo:  cmp_d[31:0]  = merge_bytes(cmp_q[31:0], dat_i, sel);
                RegCmpHi:  cmp_d[63:32] = merge_bytes(cmp_q[63:32], dat_i, sel);
                RegTimeLo: mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], dat_i, sel)};
                RegTimeHi: mtime_d = {merge_bytes(mtime_q[63:32], dat_i, sel), mtime_q[31:0]};
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            presc_q <= '0;
            mtime_q <= '0;
            cmp_q   <= MTIMECMP_RESET;
            msip_q  <= 1'b0;
            mtip_q  <= 1'b0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            presc_q <= presc_d;
            mtime_q <= mtime_d;
            cmp_q   <= cmp_d;
            msip_q  <= msip_d;
            mtip_q  <= mtip_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
        end
    end

    assign dat_o   = dat_q;
    assign ack     = ack_q;
    assign msip    = msip_q;
    assign mtip    = mtip_q;
    assign mtime_o = mtime_q;

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: table-driven register vectors, corner-case sequences and a
// randomized bus run checked every cycle against a behavioural CLINT model.
module tb_clint_timer;

    logic        clock;
    logic        reset;
    logic        cyc, stb, we;
    logic [15:0] addr;
    logic [3:0]  sel;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack, msip, mtip;
    logic [63:0] mtime_o;

    logic [31:0] d4_dat;
    logic        d4_ack, d4_msip, d4_mtip;
    logic [63:0] d4_mtime;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [63:0] m_time, m_cmp;
    logic        m_msip, m_mtip, m_ack;
    logic [31:0] m_dat;
    int          n4;

    clint_timer #(.CLOCK_DIV(1)) dut (
        .clock(clock), .reset(reset), .cyc(cyc), .stb(stb), .we(we), .addr(addr),
        .sel(sel), .dat_i(dat_i), .dat_o(dat_o), .ack(ack), .msip(msip), .mtip(mtip),
        .mtime_o(mtime_o)
    );

    clint_timer #(.CLOCK_DIV(4)) dut4 (
        .clock(clock), .reset(reset), .cyc(1'b0), .stb(1'b0), .we(1'b0), .addr(16'h0),
        .sel(4'h0), .dat_i(32'h0), .dat_o(d4_dat), .ack(d4_ack), .msip(d4_msip),
        .mtip(d4_mtip), .mtime_o(d4_mtime)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = n[i*8 +: 8];
        return r;
    endfunction

    // Advance one clock: predict from the CLINT rules, then compare every output.
    task automatic step();
        logic        req, s_n, t_n_mtip, a_n;
        logic [63:0] t_n, c_n;
        logic [31:0] d_n;
        logic [15:0] a;
        a = {addr[15:2], 2'b00};
        if (reset) begin
            t_n = '0; c_n = '1; s_n = 0; t_n_mtip = 0; a_n = 0; d_n = '0;
        end else begin
            req = cyc && stb && !m_ack;
            t_n = m_time + 64'd1;
            c_n = m_cmp;
            s_n = m_msip;
            t_n_mtip = (m_time >= m_cmp);
            a_n = req;
            d_n = '0;
            if (req && !we) begin
                if (a == 16'h0000) d_n = {31'd0, m_msip};
                else if (a == 16'h4000) d_n = m_cmp[31:0];
                else if (a == 16'h4004) d_n = m_cmp[63:32];
                else if (a == 16'hBFF8) d_n = m_time[31:0];
                else if (a == 16'hBFFC) d_n = m_time[63:32];
            end
            if (req && we) begin
                if (a == 16'h0000 && sel[0]) s_n = dat_i[0];
                else if (a == 16'h4000) c_n[31:0] = bmerge(m_cmp[31:0], dat_i, sel);
                else if (a == 16'h4004) c_n[63:32] = bmerge(m_cmp[63:32], dat_i, sel);
                else if (a == 16'hBFF8) t_n = {m_time[63:32], bmerge(m_time[31:0], dat_i, sel)};
                else if (a == 16'hBFFC) t_n = {bmerge(m_time[63:32], dat_i, sel), m_time[31:0]};
            end
        end
        @(posedge clock);
        #1;
        m_time = t_n; m_cmp = c_n; m_msip = s_n; m_mtip = t_n_mtip; m_ack = a_n; m_dat = d_n;
        n4 = reset ? 0 : n4 + 1;
        check("mtime", mtime_o, m_time);
        check("mtip", mtip, m_mtip);
        check("msip", msip, m_msip);
        check("ack", ack, m_ack);
        check("dat_o", dat_o, m_dat);
        check("div4_mtime", d4_mtime, 64'(n4 / 4));
        check("div4_mtip", d4_mtip, 0);
    endtask

    task automatic idle();
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic do_reset(input int n);
        idle();
        reset = 1;
        repeat (n) step();
        reset = 0;
    endtask

    // Returns in the ack cycle with the request already dropped.
    task automatic bus(input logic w, input logic [15:0] a, input logic [3:0] s,
                       input logic [31:0] d, output logic [31:0] rd);
        if (m_ack) begin
            idle();
            step();
        end
        cyc = 1; stb = 1; we = w; addr = a; sel = s; dat_i = d;
        step();
        check("bus_ack", ack, 1);
        rd = dat_o;
        idle();
    endtask

    typedef struct {
        logic        w;
        logic [15:0] a;
        logic [3:0]  s;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl[16];
    logic [31:0] rd;
    logic [31:0] prev;
    logic [15:0] addrs[6];

    initial begin
        tbl[0]  = '{1'b1, 16'h4000, 4'hF, 32'h1234_5678, 32'h0};
        tbl[1]  = '{1'b0, 16'h4000, 4'h0, 32'h0,         32'h1234_5678};
        tbl[2]  = '{1'b1, 16'h4000, 4'h2, 32'hAABB_CCDD, 32'h0};
        tbl[3]  = '{1'b0, 16'h4002, 4'h0, 32'h0,         32'h1234_CC78};
        tbl[4]  = '{1'b1, 16'h4004, 4'h8, 32'h9900_0000, 32'h0};
        tbl[5]  = '{1'b0, 16'h4004, 4'h0, 32'h0,         32'h99FF_FFFF};
        tbl[6]  = '{1'b1, 16'h4004, 4'h5, 32'h0055_0033, 32'h0};
        tbl[7]  = '{1'b0, 16'h4004, 4'h0, 32'h0,         32'h9955_FF33};
        tbl[8]  = '{1'b0, 16'h0000, 4'h0, 32'h0,         32'h0};
        tbl[9]  = '{1'b1, 16'h0000, 4'hF, 32'hFFFF_FFFF, 32'h0};
        tbl[10] = '{1'b0, 16'h0000, 4'h0, 32'h0,         32'h1};
        tbl[11] = '{1'b1, 16'h0000, 4'h1, 32'hFFFF_FFFE, 32'h0};
        tbl[12] = '{1'b0, 16'h0003, 4'h0, 32'h0,         32'h0};
        tbl[13] = '{1'b1, 16'h1234, 4'hF, 32'hDEAD_BEEF, 32'h0};
        tbl[14] = '{1'b0, 16'h1234, 4'h0, 32'h0,         32'h0};
        tbl[15] = '{1'b0, 16'hBFF4, 4'h0, 32'h0,         32'h0};
        addrs[0] = 16'h0000; addrs[1] = 16'h4000; addrs[2] = 16'h4004;
        addrs[3] = 16'hBFF8; addrs[4] = 16'hBFFC; addrs[5] = 16'h0000;

        reset = 1; addr = '0; sel = '0; dat_i = '0;
        m_ack = 0; n4 = 0;
        idle();

        // Reset state and free-running count
        do_reset(2);
        check("rst_mtime", mtime_o, 0);
        check("rst_mtip", mtip, 0);
        check("rst_msip", msip, 0);
        check("rst_ack", ack, 0);
        for (int k = 1; k <= 3; k++) begin
            step();
            check("count", mtime_o, 64'(k));
        end
        bus(1'b0, 16'h4004, 4'h0, 32'h0, rd);
        check("rst_cmp_hi", rd, 32'hFFFF_FFFF);

        // Register vectors
        for (int i = 0; i < 16; i++) begin
            bus(tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].d, rd);
            check($sformatf("tbl%0d", i), rd, tbl[i].exp);
        end

        // Prescaler
        do_reset(1);
        for (int i = 1; i <= 40; i++) begin
            step();
            check("presc_step", d4_mtime, 64'(i / 4));
        end
        check("presc_final", d4_mtime, 64'd10);

        // Timer interrupt
        do_reset(1);
        bus(1'b1, 16'h4004, 4'hF, 32'h0, rd);
        bus(1'b1, 16'h4000, 4'hF, 32'd20, rd);
        idle();
        for (int i = 0; i < 100 && mtime_o != 64'd20; i++) step();
        check("tmr_reach20", mtime_o, 64'd20);
        check("tmr_mtip_pre", mtip, 0);
        step();
        check("tmr_mtip_rise", mtip, 1);
        bus(1'b1, 16'h4004, 4'hF, 32'h1, rd);
        step();
        check("tmr_mtip_clr", mtip, 0);

        // Software interrupt and byte lanes
        bus(1'b1, 16'h0000, 4'b0001, 32'h1, rd);
        check("msip_set", msip, 1);
        bus(1'b1, 16'h0000, 4'b0000, 32'h0, rd);
        check("msip_sel0", msip, 1);
        bus(1'b1, 16'h0000, 4'b0001, 32'h0, rd);
        check("msip_clr", msip, 0);

        // Wrap and write priority
        bus(1'b1, 16'hBFFC, 4'hF, 32'hFFFF_FFFF, rd);
        bus(1'b1, 16'hBFF8, 4'hF, 32'hFFFF_FFFE, rd);
        check("wrap_written", mtime_o, 64'hFFFF_FFFF_FFFF_FFFE);
        step();
        check("wrap_max", mtime_o, 64'hFFFF_FFFF_FFFF_FFFF);
        check("wrap_mtip_hi", mtip, 1);
        step();
        check("wrap_zero", mtime_o, 64'h0);
        step();
        check("wrap_mtip_lo", mtip, 0);

        // Handshake: held request acks every other cycle
        idle();
        step();
        check("hs_ack0", ack, 0);
        cyc = 1; stb = 1; we = 0; addr = 16'hBFF8;
        for (int i = 1; i <= 5; i++) begin
            prev = m_time[31:0];
            step();
            check("hs_ack", ack, (i % 2));
            if (i % 2 == 1) check("hs_dat", dat_o, prev);
        end
        idle();
        step();
        bus(1'b0, 16'h1234, 4'h0, 32'h0, rd);
        check("unmapped_rd", rd, 32'h0);

        // Reset coinciding with a request: no ack, no write
        idle();
        step();
        cyc = 1; stb = 1; we = 1; addr = 16'h0000; sel = 4'h1; dat_i = 32'h1;
        reset = 1;
        step();
        check("rstreq_ack", ack, 0);
        check("rstreq_msip", msip, 0);
        reset = 0;
        idle();
        step();
        check("rstreq_ack2", ack, 0);
        check("rstreq_msip2", msip, 0);

        // Randomized bus traffic
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            cyc   = ($urandom_range(0, 3) != 0);
            stb   = ($urandom_range(0, 3) != 0);
            we    = $urandom_range(0, 1);
            addr  = ($urandom_range(0, 7) == 0) ? 16'($urandom) :
                    (addrs[$urandom_range(0, 5)] | 16'($urandom_range(0, 3)));
            sel   = 4'($urandom);
            dat_i = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15))
                                                : $urandom;
            step();
        end
        reset = 0;
        idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clint_timer.md
Name: clint_timer

Overview:
- Core-local interruptor for a single hart: the interrupt-source end of the machine interrupt lines that the CSR unit samples into mip.MSIP (bit 3) and mip.MTIP (bit 7).
- Holds a 64-bit mtime counter, a 64-bit mtimecmp register and a software-interrupt bit msip.
- All three are memory-mapped behind a 32-bit Wishbone-style slave port.
- Also exports mtime so the core can serve the time CSR.

Parameters:
- CLOCK_DIV, 1, clock cycles per mtime increment; legal range 1..65535.
- MTIMECMP_RESET, 64'hFFFF_FFFF_FFFF_FFFF, reset value of mtimecmp.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- cyc  input  1  bus cycle valid.
- stb  input  1  strobe; a request is cyc & stb.
- we  input  1  1 = write, 0 = read.
- addr  input  16  byte offset inside the CLINT window.
- sel  input  4  byte-lane enables for writes.
- dat_i  input  32  write data.
- dat_o  output  32  read data; valid while ack is 1.
- ack  output  1  one-cycle acknowledge.
- msip  output  1  machine software interrupt pending (drives MSI).
- mtip  output  1  machine timer interrupt pending (drives MTI).
- mtime_o  output  64  current mtime value.

Behaviour:
- Reset (reset = 1 at a clock edge) forces:
  - mtime = 0, prescaler = 0, mtimecmp = MTIMECMP_RESET, msip = 0, mtip = 0, ack = 0, dat_o = 0.
  - Reset mid-transaction drops the pending ack; no register write takes effect.
- Register map (32-bit aligned; addr[1:0] ignored):
  - 0x0000: msip; bit 0 is RW, bits 31:1 read 0.
  - 0x4000: mtimecmp[31:0].
  - 0x4004: mtimecmp[63:32].
  - 0xBFF8: mtime[31:0].
  - 0xBFFC: mtime[63:32].
  - Any other address reads 0, ignores writes, and is still acked.
- Bus handshake:
  - A request seen at edge N while ack = 0 is accepted. At edge N+1: ack = 1, dat_o holds the read data, and any write is committed.
  - ack is high for exactly one cycle.
  - While ack = 1, the request is not re-accepted. Back-to-back requests therefore complete at most every 2 cycles.
  - dat_o = 0 when ack = 0 and on write acks.
  - Writes are per byte lane: only bytes with sel[i] = 1 change. sel = 0 is acked with no effect.
- Prescaler and mtime:
  - The prescaler counts 0..CLOCK_DIV-1 and emits a tick when it equals CLOCK_DIV-1, then returns to 0.
  - With CLOCK_DIV = 1 there is a tick every cycle.
  - On a tick, mtime increments by 1. It wraps from 2^64-1 to 0 with no flag.
  - A bus write to either mtime half on a tick cycle wins: the written bytes take the write data, the whole 64-bit value is not incremented that cycle, and the prescaler keeps running.
  - A read returns mtime as it was before that edge's increment.
  - There is no carry protection between the halves; software uses the hi/lo/hi read sequence.
- mtip is registered: mtip <= (mtime >= mtimecmp), unsigned 64-bit compare, evaluated on register values before the edge. It lags a register change by one cycle.
  - Writing mtimecmp above mtime clears mtip one cycle after the write ack.
- msip = msip register bit 0. It is set or cleared only by bus writes.
- mtime_o = mtime register, with no extra latency.

Test Plan:
- Reset check:
  - Hold reset 2 cycles, then release with CLOCK_DIV = 1.
  - Required: mtime_o = 0, 1, 2, … each cycle; mtip = 0; msip = 0; ack = 0; read of 0x4004 returns 0xFFFFFFFF.
- Prescaler:
  - CLOCK_DIV = 4; run 40 cycles after reset.
  - Required: mtime_o = 10, and it steps exactly every 4th cycle.
- Timer interrupt:
  - Write 0x4004 = 0, then write 0x4000 = 20.
  - Required: mtip rises exactly one cycle after mtime_o reaches 20.
  - Then write 0x4004 = 1. Required: mtip = 0 one cycle after that ack.
- Software interrupt and byte lanes:
  - Write 0x0000 = 1 with sel = 4'b0001. Required: msip = 1 at the ack edge.
  - Write 0x0000 = 0 with sel = 4'b0000. Required: acked and msip stays 1.
  - Write 0x0000 = 0 with sel = 4'b0001. Required: msip = 0.
- Wrap and write-priority:
  - Write mtime halves to 0xFFFFFFFF_FFFFFFFE, then let it run.
  - Required: the value after the write is held for one cycle; mtime_o then reads …FFFF and then 0, and mtip stays consistent with mtimecmp.
  - A write on a tick cycle leaves exactly the written value, not value+1.
- Handshake robustness:
  - Hold cyc = stb = 1 for 6 cycles on a read of 0xBFF8.
  - Required: ack pattern 0,1,0,1,0,1, each ack carrying the then-current mtime[31:0].
  - Read 0x1234. Required: ack with dat_o = 0.
  - Assert reset in the cycle after acceptance. Required: no ack.
